// File: rtl/gf8_pkg.sv
// Shared GF(2^8) definitions for the AES field (x^8+x^4+x^3+x+1).
//   GF8_POLY       low byte of the reduction polynomial
//   GF8_ONE        multiplicative identity
//   GF8_INV_ITERS  square-and-multiply steps needed to form y^254
//   state_t        divider FSM states
package gf8_pkg;

  localparam logic [7:0] GF8_POLY      = 8'h1B;
  localparam logic [7:0] GF8_ONE       = 8'h01;
  localparam int         GF8_INV_ITERS = 7;
  localparam logic [2:0] GF8_LAST_ITER = 3'(GF8_INV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gmul8.sv
// Combinational GF(2^8) multiplier over the AES field.
//   a, b : 8-bit field elements
//   p    : a * b reduced modulo x^8+x^4+x^3+x+1
// Shift-and-add: the running multiple of a is reduced by GF8_POLY each time
// bit 7 shifts out, so nothing wider than 8 bits is ever formed.
module gmul8
  import gf8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] mult;

  always_comb begin
    acc  = 8'h00;
    mult = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ mult;
      mult = {mult[6:0], 1'b0} ^ (mult[7] ? GF8_POLY : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/gf8_div_seq.sv
// Iterative GF(2^8) divider: q = x * y^-1 = x * y^254, one square-and-
// multiply step per clock, seven steps per division.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     operand pair x/y offered
//   in_ready     divider idle and able to take operands
//   x, y         dividend, divisor
//   out_valid    q / div_by_zero hold a result, kept until accepted
//   out_ready    consumer takes the result
//   q            quotient (0 when y = 0)
//   div_by_zero  result came from y = 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; once
// raised, out_valid and the result stay unchanged until out_ready is seen.
// A result handshake returns to IDLE, so a new operand pair is taken no
// earlier than the following edge.
module gf8_div_seq
  import gf8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic       div_by_zero
);

  state_t     state;
  logic [7:0] acc;
  logic [7:0] s;
  logic [2:0] cnt;
  logic       dz;

  logic [7:0] s_sq;
  logic [7:0] acc_next;

  // s holds y^(2^k); acc gathers x * y^(2+4+...+2^(k+1)).
  gmul8 u_square (.a(s),   .b(s),    .p(s_sq));
  gmul8 u_accum  (.a(acc), .b(s_sq), .p(acc_next));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      q           <= 8'h00;
      div_by_zero <= 1'b0;
      acc         <= 8'h00;
      s           <= 8'h00;
      cnt         <= 3'd0;
      dz          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= x;
            s        <= y;
            cnt      <= 3'd0;
            dz       <= (y == 8'h00);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s   <= s_sq;
          acc <= acc_next;
          cnt <= cnt + 3'd1;
          if (cnt == GF8_LAST_ITER) begin
            // acc_next is now x * y^254; y = 0 falls out as 0 on its own.
            q           <= acc_next;
            div_by_zero <= dz;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
